// File: rtl/mem_arb_2432.sv
// Single-port RAM arbiter and step sequencer for cpu_2432: time-shares one
// synchronous RAM between instruction fetch, CPU data access and a host port.
module mem_arb_2432 #(
    parameter int ADDR_W     = 16,
    parameter int HOST_FIRST = 1
) (
    input  logic              i_clk,
    input  logic              i_rstb,
    input  logic              i_run,
    input  logic [23:0]       i_cpu_iaddr,
    input  logic [23:0]       i_cpu_daddr,
    input  logic [31:0]       i_cpu_dout,
    input  logic              i_cpu_ram_rd,
    input  logic [3:0]        i_cpu_ram_wr,
    output logic              o_cpu_clk_en,
    output logic [23:0]       o_cpu_instr,
    output logic [31:0]       o_cpu_din,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [31:0]       i_host_wdata,
    output logic              o_host_ack,
    output logic [31:0]       o_host_rdata,
    output logic              o_mem_en,
    output logic [3:0]        o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    output logic [31:0]       o_steps
);

    typedef enum logic [2:0] {
        ARB,
        HCAP,
        ICAP,
        DCAP,
        STEP
    } state_t;

    state_t              state_q, state_d;
    logic                host_last_q;
    logic                host_we_q;
    logic [23:0]         instr_q;
    logic [31:0]         din_q;
    logic [31:0]         rdata_q;
    logic [31:0]         steps_q;

    logic                grant_host;
    logic                grant_cpu;
    logic                mem_en;
    logic [3:0]          mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_wdata;

    // Upper CPU address bits fall outside the RAM and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_cpu_iaddr[23:ADDR_W], i_cpu_daddr[23:ADDR_W]};

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        grant_host = 1'b0;
        grant_cpu  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            ARB: begin
                if (i_host_req && i_run) begin
                    grant_host = host_last_q ? 1'b0 : (HOST_FIRST != 0);
                end else begin
                    grant_host = i_host_req;
                end
                grant_cpu = i_run && !grant_host;
                if (grant_host) begin
                    mem_en    = 1'b1;
                    mem_we    = {4{i_host_we}};
                    mem_addr  = i_host_addr;
                    mem_wdata = i_host_wdata;
                    state_d   = HCAP;
                end else if (grant_cpu) begin
                    mem_en   = 1'b1;
                    mem_addr = i_cpu_iaddr[ADDR_W-1:0];
                    state_d  = ICAP;
                end
            end
            HCAP: state_d = ARB;
            ICAP: begin
                // A store takes priority over a load requested in the same step.
                if (i_cpu_ram_wr != 4'b0000) begin
                    mem_en    = 1'b1;
                    mem_we    = i_cpu_ram_wr;
                    mem_addr  = i_cpu_daddr[ADDR_W-1:0];
                    mem_wdata = i_cpu_dout;
                    state_d   = STEP;
                end else if (i_cpu_ram_rd) begin
                    mem_en   = 1'b1;
                    mem_addr = i_cpu_daddr[ADDR_W-1:0];
                    state_d  = DCAP;
                end else begin
                    state_d = STEP;
                end
            end
            DCAP:    state_d = STEP;
            STEP:    state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state_q     <= ARB;
            host_last_q <= 1'b0;
            host_we_q   <= 1'b0;
            instr_q     <= '0;
            din_q       <= '0;
            rdata_q     <= '0;
            steps_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ARB: begin
                    if (grant_host) begin
                        host_last_q <= 1'b1;
                        host_we_q   <= i_host_we;
                    end else if (grant_cpu) begin
                        host_last_q <= 1'b0;
                    end
                end
                HCAP: if (!host_we_q) rdata_q <= i_mem_rdata;
                ICAP: instr_q <= i_mem_rdata[23:0];
                DCAP: din_q   <= i_mem_rdata;
                STEP: steps_q <= steps_q + 32'd1;
                default: ;
            endcase
        end
    end

    // Reset also gates the RAM strobe so an in-flight store is withdrawn at once.
    assign o_mem_en    = i_rstb & mem_en;
    assign o_mem_we    = i_rstb ? mem_we : 4'b0000;
    assign o_mem_addr  = i_rstb ? mem_addr : '0;
    assign o_mem_wdata = i_rstb ? mem_wdata : '0;

    assign o_cpu_clk_en = (state_q == STEP);
    assign o_cpu_instr  = instr_q;
    assign o_cpu_din    = din_q;
    assign o_steps      = steps_q;
    assign o_host_ack   = (state_q == HCAP);
    // Read data bypasses the holding register so it is already valid with ack.
    assign o_host_rdata = (state_q == HCAP && !host_we_q) ? i_mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_arb_2432.sv
// Scoreboard bench for mem_arb_2432: random CPU steps and host traffic checked
// against a word-level memory model, plus step timing and reset behaviour.
module tb_mem_arb_2432;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [23:0] cpu_iaddr = '0;
    logic [23:0] cpu_daddr = '0;
    logic [31:0] cpu_dout = '0;
    logic        cpu_ram_rd = 1'b0;
    logic [3:0]  cpu_ram_wr = '0;
    logic        cpu_clk_en;
    logic [23:0] cpu_instr;
    logic [31:0] cpu_din;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [15:0] host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] steps;

    always #5 clk = ~clk;

    mem_arb_2432 #(.ADDR_W(16), .HOST_FIRST(1)) dut (
        .i_clk(clk), .i_rstb(rst_n), .i_run(run),
        .i_cpu_iaddr(cpu_iaddr), .i_cpu_daddr(cpu_daddr), .i_cpu_dout(cpu_dout),
        .i_cpu_ram_rd(cpu_ram_rd), .i_cpu_ram_wr(cpu_ram_wr),
        .o_cpu_clk_en(cpu_clk_en), .o_cpu_instr(cpu_instr), .o_cpu_din(cpu_din),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr),
        .i_host_wdata(host_wdata), .o_host_ack(host_ack), .o_host_rdata(host_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_steps(steps)
    );

    // Synchronous RAM: one-cycle read latency, byte-lane writes at the strobe edge.
    logic [31:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model: word memory plus the architectural CPU/host state.
    typedef struct {
        logic [23:0] instr;
        logic [31:0] din;
        logic [31:0] steps;
    } cpu_exp_t;

    logic [31:0] ref_mem [0:65535];
    cpu_exp_t    cpu_q[$];
    logic [31:0] host_q[$];
    logic [31:0] m_din = '0;
    logic [31:0] m_steps = '0;
    logic [31:0] m_hrdata = '0;
    int          mode = 0;

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  pulses = 0;
    int  pcyc[$];
    byte ev[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    task automatic preload(input int a, input logic [31:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    // Presents the next CPU step and records what the DUT must show at its pulse.
    task automatic cpu_present();
        logic [23:0] ia, da;
        logic [31:0] dout;
        logic        rd;
        logic [3:0]  wr;
        int          kind;
        cpu_exp_t    e;
        ia   = {8'($urandom), 16'($urandom_range(0, 63))};
        da   = {8'($urandom), 16'(64 + $urandom_range(0, 63))};
        dout = $urandom;
        rd   = 1'b0;
        wr   = 4'b0000;
        case (mode)
            0: ia = {8'($urandom), 16'h0000};
            1: begin da = {8'($urandom), 16'h0020}; rd = 1'b1; end
            2: begin
                ia = 24'h000000; da = 24'h000030; rd = 1'b1; wr = 4'b0100; dout = 32'h00AA0000;
            end
            default: begin
                kind = $urandom_range(0, 2);
                if (kind == 1) rd = 1'b1;
                if (kind == 2) begin wr = 4'($urandom_range(1, 15)); rd = 1'($urandom); end
            end
        endcase
        cpu_iaddr = ia; cpu_daddr = da; cpu_dout = dout; cpu_ram_rd = rd; cpu_ram_wr = wr;
        e.instr = ref_mem[ia[15:0]][23:0];
        if (wr != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (wr[b]) ref_mem[da[15:0]][8*b +: 8] = dout[8*b +: 8];
        end else if (rd) begin
            m_din = ref_mem[da[15:0]];
        end
        e.din   = m_din;
        e.steps = m_steps;
        m_steps = m_steps + 32'd1;
        cpu_q.push_back(e);
    endtask

    // CPU stand-in: advances to its next step right after each clock-enable pulse.
    always @(negedge clk) begin
        if (rst_n && cpu_clk_en) begin
            @(posedge clk);
            #1;
            cpu_present();
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard whenever the DUT presents a pulse or an ack.
    always @(negedge clk) begin
        cpu_exp_t    e;
        logic [31:0] hr;
        if (cpu_clk_en) pulses++;
        if (rst_n && cpu_clk_en) begin
            pcyc.push_back(cyc);
            ev.push_back(8'h43);
            if (cpu_q.size() == 0) fail_now("cpu_unexpected_pulse");
            else begin
                e = cpu_q.pop_front();
                check("cpu_instr", {8'h00, cpu_instr}, {8'h00, e.instr});
                check("cpu_din", cpu_din, e.din);
                check("cpu_steps", steps, e.steps);
            end
        end
        if (rst_n && host_ack) begin
            ev.push_back(8'h48);
            if (host_q.size() == 0) fail_now("host_unexpected_ack");
            else begin
                hr = host_q.pop_front();
                check("host_rdata", host_rdata, hr);
            end
        end
        if (rst_n && cpu_clk_en && host_ack) fail_now("ack_and_clk_en_together");
    end

    task automatic host_op(input logic we, input logic [15:0] a, input logic [31:0] d, input bit chk_cost);
        int n;
        bit got;
        if (we) ref_mem[a] = d;
        else    m_hrdata = ref_mem[a];
        host_q.push_back(m_hrdata);
        @(posedge clk); #1;
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (host_ack) got = 1'b1;
        end
        if (!got) fail_now("host_ack_timeout");
        else if (chk_cost) check("host_cost", 32'(n), 32'd2);
        @(posedge clk); #1;
        host_req = 1'b0; host_we = 1'b0;
    endtask

    // Waits for n more pulses, stops the CPU, then checks the pulse spacing.
    task automatic wait_pulses(input int n, input int gap);
        int target, start, t;
        target = pulses + n;
        start  = pcyc.size();
        t      = 0;
        while (pulses < target && t < 100 * n) begin
            @(negedge clk); #1;
            t++;
        end
        if (pulses < target) fail_now("pulse_timeout");
        @(posedge clk); #1;
        run = 1'b0;
        if (gap > 0)
            for (int i = start + 1; i < pcyc.size(); i++)
                check("step_period", 32'(pcyc[i] - pcyc[i-1]), 32'(gap));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, n_same, n_h, n_c;
        for (int a = 0; a < 256; a++) preload(a, $urandom);
        preload(0, 32'h00ABCDEF);
        preload(32'h20, 32'hDEADBEEF);
        preload(32'h30, 32'h11223344);

        // Reset with live requests on every input: all outputs must read 0.
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0005; host_wdata = 32'hCAFEF00D; run = 1'b1;
        #12;
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {28'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_clk_en", {31'd0, cpu_clk_en}, 32'd0);
        check("rst_instr", {8'd0, cpu_instr}, 32'd0);
        check("rst_din", cpu_din, 32'd0);
        check("rst_ack", {31'd0, host_ack}, 32'd0);
        check("rst_rdata", host_rdata, 32'd0);
        check("rst_steps", steps, 32'd0);
        host_req = 1'b0; host_we = 1'b0; run = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Host write then read back, CPU idle.
        host_op(1'b1, 16'h0010, 32'h12345678, 1'b1);
        host_op(1'b0, 16'h0010, 32'h0, 1'b1);
        check("host_phase_pulses", 32'(pulses), 32'd0);

        // Fetch-only steps from address 0.
        mode = 0;
        cpu_present();
        @(posedge clk); #1; run = 1'b1;
        @(negedge clk);
        check("fetch_en", {31'd0, mem_en}, 32'd1);
        check("fetch_we", {28'd0, mem_we}, 32'd0);
        check("fetch_addr", {16'd0, mem_addr}, 32'd0);
        wait_pulses(5, 3);

        // Loads from 0x20.
        mode = 1; run = 1'b1;
        wait_pulses(5, 4);

        // Byte-lane store to 0x30 with a simultaneous read request.
        mode = 2; run = 1'b1;
        wait_pulses(4, 3);
        host_op(1'b0, 16'h0030, 32'h0, 1'b0);

        // Reset in ICAP of a store: strobe withdrawn, no pulse, fresh fetch afterwards.
        run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("icap_store_we", {28'd0, mem_we}, 32'h4);
        p0 = pulses;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_we", {28'd0, mem_we}, 32'd0);
        check("midrst_mem_en", {31'd0, mem_en}, 32'd0);
        check("midrst_instr", {8'd0, cpu_instr}, 32'd0);
        check("midrst_rdata", host_rdata, 32'd0);
        check("midrst_steps", steps, 32'd0);
        repeat (3) @(posedge clk);
        check("midrst_no_pulse", 32'(pulses), 32'(p0));
        cpu_q.delete();
        m_din = '0; m_steps = '0; m_hrdata = '0;
        mode = 0;
        cpu_present();
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("fresh_fetch_en", {31'd0, mem_en}, 32'd1);
        check("fresh_fetch_we", {28'd0, mem_we}, 32'd0);
        check("fresh_fetch_addr", {16'd0, mem_addr}, 32'd0);
        wait_pulses(3, 3);

        // Host and CPU both busy: grants must alternate.
        mode = 3;
        ev.delete();
        run = 1'b1;
        for (int i = 0; i < 6; i++) host_op(1'b0, 16'(128 + $urandom_range(0, 127)), 32'h0, 1'b0);
        run = 1'b0;
        repeat (4) @(posedge clk);
        n_same = 0; n_h = 0; n_c = 0;
        foreach (ev[i]) begin
            if (ev[i] == 8'h48) n_h++; else n_c++;
            if (i > 0 && ev[i] == ev[i-1]) n_same++;
        end
        check("alt_repeats", 32'(n_same), 32'd0);
        check("alt_host_grants", 32'(n_h), 32'd6);
        check("alt_cpu_grants", 32'(n_c), 32'd6);

        // Random mix of CPU steps and host traffic, then read back the CPU data region.
        run = 1'b1;
        fork
            wait_pulses(40, 0);
            begin
                for (int i = 0; i < 20; i++) begin
                    repeat ($urandom_range(0, 5)) @(posedge clk);
                    host_op(1'($urandom), 16'(128 + $urandom_range(0, 127)), $urandom, 1'b0);
                end
            end
        join
        repeat (6) @(posedge clk);
        for (int a = 64; a < 128; a++) host_op(1'b0, 16'(a), 32'h0, 1'b0);

        repeat (4) @(posedge clk);
        check("host_q_drained", 32'(host_q.size()), 32'd0);
        check("cpu_q_one_pending", 32'(cpu_q.size()), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
